// File: rtl/apb2_master.sv
// APB requester bridge: turns a valid/ready command into one APB SETUP/ACCESS
// transfer and returns the completion on a valid/ready response channel.
module apb2_master #(
    parameter  int data_width     = 32,
    parameter  int addr_width     = 8,
    parameter  int timeout_cycles = 255,
    localparam int strobe_count   = data_width / 8
) (
    input  logic                    pclk,
    input  logic                    preset_n,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [addr_width-1:0]   cmd_addr,
    input  logic [data_width-1:0]   cmd_wdata,
    input  logic [strobe_count-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,

    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [data_width-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,

    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [addr_width-1:0]   paddr,
    output logic [data_width-1:0]   pwdata,
    output logic [strobe_count-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [data_width-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int cnt_w = (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
    localparam logic [cnt_w-1:0] timeout_val = cnt_w'(timeout_cycles);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  r_state,       w_state_nxt;
    logic [cnt_w-1:0]        r_cnt,         w_cnt;
    logic                    r_cmd_ready,   w_cmd_ready;
    logic                    r_rsp_valid,   w_rsp_valid;
    logic [data_width-1:0]   r_rsp_rdata,   w_rsp_rdata;
    logic                    r_rsp_err,     w_rsp_err;
    logic                    r_rsp_timeout, w_rsp_timeout;
    logic                    r_psel,        w_psel;
    logic                    r_penable,     w_penable;
    logic                    r_pwrite,      w_pwrite;
    logic [addr_width-1:0]   r_paddr,       w_paddr;
    logic [data_width-1:0]   r_pwdata,      w_pwdata;
    logic [strobe_count-1:0] r_pstrb,       w_pstrb;
    logic [2:0]              r_pprot,       w_pprot;

    logic [cnt_w-1:0]        w_cnt_inc;
    logic                    w_timeout_hit;

    assign w_cnt_inc     = r_cnt + cnt_w'(1);
    assign w_timeout_hit = (timeout_cycles != 0) && (w_cnt_inc == timeout_val);

    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch can leave one unassigned and infer a latch.
        w_state_nxt   = r_state;
        w_cnt         = r_cnt;
        w_cmd_ready   = r_cmd_ready;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_rdata   = r_rsp_rdata;
        w_rsp_err     = r_rsp_err;
        w_rsp_timeout = r_rsp_timeout;
        w_psel        = r_psel;
        w_penable     = r_penable;
        w_pwrite      = r_pwrite;
        w_paddr       = r_paddr;
        w_pwdata      = r_pwdata;
        w_pstrb       = r_pstrb;
        w_pprot       = r_pprot;

        case (r_state)
            ST_IDLE: begin
                w_psel      = 1'b0;
                w_penable   = 1'b0;
                w_rsp_valid = 1'b0;
                w_cmd_ready = 1'b1;
                w_cnt       = '0;
                if (cmd_valid && r_cmd_ready) begin
                    w_pwrite    = cmd_write;
                    w_paddr     = cmd_addr;
                    w_pwdata    = cmd_wdata;
                    w_pstrb     = cmd_write ? cmd_strb : '0;
                    w_pprot     = cmd_prot;
                    w_cmd_ready = 1'b0;
                    w_psel      = 1'b1;
                    w_state_nxt = ST_SETUP;
                end
            end

            ST_SETUP: begin
                w_psel      = 1'b1;
                w_penable   = 1'b1;
                w_cnt       = '0;
                w_state_nxt = ST_ACCESS;
            end

            ST_ACCESS: begin
                if (pready) begin
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_rdata   = r_pwrite ? '0 : prdata;
                    w_rsp_err     = pslverr;
                    w_rsp_timeout = 1'b0;
                    w_state_nxt   = ST_RESP;
                end else if (w_timeout_hit) begin
                    w_psel        = 1'b0;
                    w_penable     = 1'b0;
                    w_rsp_valid   = 1'b1;
                    w_rsp_rdata   = '0;
                    w_rsp_err     = 1'b1;
                    w_rsp_timeout = 1'b1;
                    w_state_nxt   = ST_RESP;
                end else if (timeout_cycles != 0) begin
                    w_cnt = w_cnt_inc;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_cnt       = '0;
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt         = '0;
                w_cmd_ready   = 1'b0;
                w_rsp_valid   = 1'b0;
                w_rsp_rdata   = '0;
                w_rsp_err     = 1'b0;
                w_rsp_timeout = 1'b0;
                w_psel        = 1'b0;
                w_penable     = 1'b0;
                w_pwrite      = 1'b0;
                w_paddr       = '0;
                w_pwdata      = '0;
                w_pstrb       = '0;
                w_pprot       = '0;
            end
        endcase
    end

    // Every output is a flop; async reset drops psel/penable and any pending response at once.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_pprot       <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt;
            r_cmd_ready   <= w_cmd_ready;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_rdata   <= w_rsp_rdata;
            r_rsp_err     <= w_rsp_err;
            r_rsp_timeout <= w_rsp_timeout;
            r_psel        <= w_psel;
            r_penable     <= w_penable;
            r_pwrite      <= w_pwrite;
            r_paddr       <= w_paddr;
            r_pwdata      <= w_pwdata;
            r_pstrb       <= w_pstrb;
            r_pprot       <= w_pprot;
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign rsp_timeout = r_rsp_timeout;
    assign psel        = r_psel;
    assign penable     = r_penable;
    assign pwrite      = r_pwrite;
    assign paddr       = r_paddr;
    assign pwdata      = r_pwdata;
    assign pstrb       = r_pstrb;
    assign pprot       = r_pprot;

endmodule

// File: tb/tb_apb2_master.sv
// Directed bench for apb2_master: write, wait-state read, slave error,
// timeout, response back-pressure and mid-transfer reset.
module tb_apb2_master;

    localparam int dw = 32;
    localparam int aw = 8;
    localparam int sw = dw / 8;

    logic          pclk = 1'b0;
    logic          preset_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [aw-1:0] cmd_addr;
    logic [dw-1:0] cmd_wdata;
    logic [sw-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [dw-1:0] rsp_rdata;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [aw-1:0] paddr;
    logic [dw-1:0] pwdata, prdata;
    logic [sw-1:0] pstrb;
    logic [2:0]    pprot;

    int total = 0;
    int bad   = 0;

    always #5 pclk = ~pclk;

    apb2_master #(.data_width(dw), .addr_width(aw), .timeout_cycles(4)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are read 1 ns later.
    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [aw-1:0] a, input logic [dw-1:0] d,
                         input logic [sw-1:0] s, input logic [2:0] p);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_strb  = s;
        cmd_prot  = p;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset_n  = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb  = '0;   cmd_prot  = '0;   rsp_ready = 1'b0;
        prdata    = '0;   pready    = 1'b0; pslverr   = 1'b0;

        // Reset state
        step(); step();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", psel, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        preset_n = 1'b1;
        step();
        check("idle_cmd_ready", cmd_ready, 1);
        check("idle_psel", {psel, penable}, 0);

        // 1: zero-wait write to 0x00
        issue(1'b1, 8'h00, 32'h1, 4'hF, 3'b101);
        pready = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("w1_setup_sel_en", {psel, penable}, 2'b10);
        check("w1_setup_cmd_ready", cmd_ready, 0);
        check("w1_pwrite", pwrite, 1);
        check("w1_pstrb", pstrb, 4'hF);
        check("w1_pwdata", pwdata, 32'h1);
        check("w1_pprot", pprot, 3'b101);
        step();
        check("w1_access_sel_en", {psel, penable}, 2'b11);
        check("w1_access_rsp_valid", rsp_valid, 0);
        step();
        check("w1_resp_sel_en", {psel, penable}, 2'b00);
        check("w1_rsp_valid", rsp_valid, 1);
        check("w1_rsp_err_to", {rsp_err, rsp_timeout}, 0);
        check("w1_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("w1_done_rsp_valid", rsp_valid, 0);
        check("w1_done_cmd_ready", cmd_ready, 1);

        // 2: read from 0x00 with two wait states; pslverr during waits is ignored
        pready = 1'b0;
        pslverr = 1'b1;
        issue(1'b0, 8'h00, 32'hDEADBEEF, 4'hF, 3'b000);
        step();
        cmd_valid = 1'b0;
        check("r2_setup_sel_en", {psel, penable}, 2'b10);
        check("r2_pstrb", pstrb, 0);
        check("r2_pwrite", pwrite, 0);
        step();
        check("r2_acc1", {psel, penable, pwrite, paddr}, {3'b110, 8'h00});
        step();
        check("r2_acc2", {psel, penable, pwrite, paddr}, {3'b110, 8'h00});
        step();
        check("r2_acc3", {psel, penable, pwrite, paddr}, {3'b110, 8'h00});
        check("r2_acc3_rsp_valid", rsp_valid, 0);
        pready = 1'b1;
        pslverr = 1'b0;
        prdata = 32'h0000_0001;
        step();
        pready = 1'b0;
        prdata = 32'hFFFF_FFFF;

        // 5: response held for five cycles while a new command is offered
        issue(1'b1, 8'h80, 32'h1234, 4'h3, 3'b000);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_rdata", rsp_rdata, 32'h1);
            check("bp_rsp_err", rsp_err, 0);
            check("bp_cmd_ready", cmd_ready, 0);
            check("bp_psel", psel, 0);
            step();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp_done_rsp_valid", rsp_valid, 0);
        check("bp_not_accepted", {psel, paddr}, {1'b0, 8'h00});
        check("bp_done_cmd_ready", cmd_ready, 1);

        // 3: write to 0x04, slave error
        issue(1'b1, 8'h04, 32'hA5A5A5A5, 4'h1, 3'b010);
        pready = 1'b1;
        pslverr = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("e3_paddr", paddr, 8'h04);
        check("e3_pstrb", pstrb, 4'h1);
        step();
        step();
        pslverr = 1'b0;
        check("e3_rsp_valid", rsp_valid, 1);
        check("e3_rsp_err_to", {rsp_err, rsp_timeout}, 2'b10);
        check("e3_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // 4: slave never ready, abort after four ACCESS cycles
        pready = 1'b0;
        prdata = 32'h5555_5555;
        issue(1'b0, 8'h08, 32'h0, 4'hF, 3'b000);
        step();
        cmd_valid = 1'b0;
        step();
        check("t4_acc1", {psel, penable}, 2'b11);
        step(); step(); step();
        check("t4_acc4", {psel, penable}, 2'b11);
        check("t4_acc4_rsp_valid", rsp_valid, 0);
        step();
        check("t4_abort_sel_en", {psel, penable}, 2'b00);
        check("t4_rsp_valid", rsp_valid, 1);
        check("t4_rsp_err_to", {rsp_err, rsp_timeout}, 2'b11);
        check("t4_rsp_rdata", rsp_rdata, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        // 6: reset asserted during an ACCESS wait state
        issue(1'b0, 8'h0C, 32'h0, 4'hF, 3'b000);
        step();
        cmd_valid = 1'b0;
        step(); step();
        check("r6_pre_sel_en", {psel, penable}, 2'b11);
        #2 preset_n = 1'b0;
        #1;
        check("r6_async_sel_en", {psel, penable}, 2'b00);
        check("r6_async_rsp_valid", rsp_valid, 0);
        check("r6_async_cmd_ready", cmd_ready, 0);
        #1 preset_n = 1'b1;
        step();
        check("r6_post_cmd_ready", cmd_ready, 1);
        pready = 1'b1;
        prdata = 32'hCAFE_0010;
        issue(1'b0, 8'h10, 32'h0, 4'hF, 3'b000);
        step();
        cmd_valid = 1'b0;
        check("r6_setup_paddr", {psel, penable, paddr}, {2'b10, 8'h10});
        step();
        step();
        check("r6_rsp_valid", rsp_valid, 1);
        check("r6_rsp_rdata", rsp_rdata, 32'hCAFE_0010);
        check("r6_rsp_err_to", {rsp_err, rsp_timeout}, 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("r6_done", {rsp_valid, cmd_ready}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb2_master.md
Name: apb2_master

Overview:
- APB requester (bus master) bridge. Converts a simple valid/ready command/response interface into APB SETUP/ACCESS transfers toward one selected peripheral, e.g. the LED slave.
- Sits between the MPU-side command logic and the APB peripherals.
- Handles one transfer at a time, with an optional ACCESS-phase timeout.

Parameters:
- data_width, 32, APB data width in bits (multiple of 8)
- addr_width, 8, APB address width in bits
- timeout_cycles, 255, max ACCESS cycles waiting for pready before abort; 0 disables timeout
- strobe_count (localparam), data_width/8, byte-strobe count

Ports:
- pclk  in  1  APB clock
- preset_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  addr_width  target address
- cmd_wdata  in  data_width  write data
- cmd_strb  in  strobe_count  write byte strobes
- cmd_prot  in  3  protection attributes
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_rdata  out  data_width  read data (0 for writes and timeouts)
- rsp_err  out  1  pslverr sampled, or timeout
- rsp_timeout  out  1  transfer aborted by timeout
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  addr_width  APB address
- pwdata  out  data_width  APB write data
- pstrb  out  strobe_count  APB strobes
- pprot  out  3  APB protection
- prdata  in  data_width  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error

Behaviour:
- Reset (async, preset_n low): state IDLE. All outputs 0, except cmd_ready=1 once out of reset. Timeout counter cleared.
- All outputs are registered.
- State IDLE:
  - cmd_ready=1, psel=0, penable=0.
  - On cmd_valid&&cmd_ready: latch paddr, pwrite, pwdata, pprot and pstrb from the command. pstrb is forced to 0 for reads. Go to SETUP.
- State SETUP (exactly 1 cycle): psel=1, penable=0, cmd_ready=0. Go to ACCESS.
- State ACCESS: psel=1, penable=1.
  - pready sampled high:
    - capture rsp_rdata = prdata for reads, 0 for writes
    - rsp_err = pslverr
    - rsp_timeout = 0
    - go to RESP
  - pready low: increment the wait counter. When the counter reaches timeout_cycles (timeout_cycles>0), abort: rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - pslverr is ignored unless pready is high.
- State RESP:
  - psel=0, penable=0, rsp_valid=1. rsp_* held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid=0, cmd_ready=1, go to IDLE. Counter cleared.
- paddr, pwrite, pwdata, pstrb and pprot are stable from SETUP through the last ACCESS cycle. They hold their last value in IDLE/RESP.
- Latency with zero-wait slave:
  - cmd accepted at edge N
  - SETUP in cycle N+1
  - ACCESS with pready in N+2
  - rsp_valid high in N+3
- Minimum spacing between commands: 4 cycles (no back-to-back pipelining).
- cmd_valid is ignored outside IDLE. Command fields are sampled only at acceptance.
- Illegal state encoding: return to IDLE, outputs cleared.
- Reset mid-transfer: psel/penable drop immediately (async). Any pending response is discarded.

Test Plan:
- Write addr 0x00, wdata 0x1, strb 0xF, slave pready=1 in first ACCESS cycle -> psel high 2 cycles, penable high 1 cycle, pwrite=1, pstrb=0xF; rsp_valid 3 cycles after accept with rsp_err=0, rsp_rdata=0.
- Read addr 0x00, slave inserts 2 wait states and then returns prdata=0x0000_0001 -> ACCESS lasts 3 cycles, pstrb=0, paddr/pwrite stable throughout; rsp_rdata=0x1, rsp_err=0.
- Write addr 0x04, slave returns pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0.
- timeout_cycles=4, slave never asserts pready -> psel/penable drop after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- rsp_ready held low 5 cycles after a read completes -> rsp_valid and rsp_rdata stable for 5 cycles, cmd_ready=0, psel=0. New cmd_valid in that window is not accepted.
- preset_n asserted during ACCESS wait state -> psel, penable and rsp_valid go 0 asynchronously. After release, cmd_ready=1 and the next read completes normally.
